// File: rtl/error_dac_if.sv
// Pulse-drive / analog-output bundle between the CDU pulse logic and error_dac.
// The master drives the pulses and controls; the slave is the DAC model.
interface error_dac_if #(
   parameter int WIDTH = 10
);
   logic                    enable;
   logic                    clear;
   logic                    plus_pulse;
   logic                    minus_pulse;
   logic signed [WIDTH-1:0] count;
   logic                    sat;
   real                     out;
   logic                    settled;

   modport master (
      output enable, clear, plus_pulse, minus_pulse,
      input  count, sat, out, settled
   );

   modport slave (
      input  enable, clear, plus_pulse, minus_pulse,
      output count, sat, out, settled
   );
endinterface

// File: rtl/error_dac.sv
// Saturating up/down error counter driving a ladder-DAC model whose real-valued
// output slews toward the DAC target by at most SLEW_VOLTS per clock.
module error_dac #(
   parameter int  WIDTH       = 10,
   parameter int  COUNT_LIMIT = 384,
   parameter real LSB_VOLTS   = 0.01,
   parameter real SLEW_VOLTS  = 0.05
) (
   input logic       clk,
   input logic       rst,
   error_dac_if.slave bus
);

   localparam logic signed [WIDTH-1:0] LIMIT_POS = WIDTH'(COUNT_LIMIT);
   localparam logic signed [WIDTH-1:0] LIMIT_NEG = -LIMIT_POS;
   // Guard band so a last step that is a hair over SLEW_VOLTS from float
   // accumulation lands on target instead of leaving a sub-nanovolt residue.
   localparam real SLEW_GUARD = SLEW_VOLTS + 1.0e-9;

   logic                    plus_q;
   logic                    minus_q;
   logic                    plus_req;
   logic                    minus_req;
   logic signed [WIDTH-1:0] count_q;
   logic signed [WIDTH-1:0] count_d;
   logic                    sat_q;
   logic                    sat_d;
   real                     out_q;
   real                     out_d;
   logic                    settled_q;
   logic                    settled_d;
   real                     target_now;
   real                     target_next;
   real                     diff;

   always_comb begin
      plus_req  = bus.plus_pulse & ~plus_q;
      minus_req = bus.minus_pulse & ~minus_q;
      count_d   = count_q;
      sat_d     = sat_q;

      if (bus.clear) begin
         count_d = '0;
         sat_d   = 1'b0;
      end else if (bus.enable) begin
         if (plus_req && !minus_req) begin
            if (count_q == LIMIT_POS) begin
               sat_d = 1'b1;
            end else begin
               count_d = count_q + 1'b1;
            end
         end else if (minus_req && !plus_req) begin
            if (count_q == LIMIT_NEG) begin
               sat_d = 1'b1;
            end else begin
               count_d = count_q - 1'b1;
            end
         end
      end
   end

   // The slew tracks the pre-edge target, so out trails count by one edge.
   always_comb begin
      target_now  = $itor(count_q) * LSB_VOLTS;
      target_next = $itor(count_d) * LSB_VOLTS;
      diff        = target_now - out_q;
      out_d       = target_now;
      if (diff > SLEW_GUARD) begin
         out_d = out_q + SLEW_VOLTS;
      end else if (diff < -SLEW_GUARD) begin
         out_d = out_q - SLEW_VOLTS;
      end
      settled_d = (out_d == target_next);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         plus_q    <= 1'b0;
         minus_q   <= 1'b0;
         count_q   <= '0;
         sat_q     <= 1'b0;
         out_q     <= 0.0;
         settled_q <= 1'b1;
      end else begin
         plus_q    <= bus.plus_pulse;
         minus_q   <= bus.minus_pulse;
         count_q   <= count_d;
         sat_q     <= sat_d;
         out_q     <= out_d;
         settled_q <= settled_d;
      end
   end

   assign bus.count   = count_q;
   assign bus.sat     = sat_q;
   assign bus.out     = out_q;
   assign bus.settled = settled_q;

endmodule

// File: tb/tb_error_dac.sv
// Bench for error_dac: constant vector table, directed corner sequences and a
// randomized run checked against an integer-count / real-voltage reference model.
module tb_error_dac;

   localparam int  WIDTH = 10;
   localparam int  LIMIT = 384;
   localparam real LSB   = 0.01;
   localparam real SLEW  = 0.05;
   localparam real TOL   = 1.0e-9;

   logic clk;
   logic rst;

   error_dac_if #(.WIDTH(WIDTH)) bus ();

   error_dac #(
      .WIDTH      (WIDTH),
      .COUNT_LIMIT(LIMIT),
      .LSB_VOLTS  (LSB),
      .SLEW_VOLTS (SLEW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   int  m_count;
   bit  m_sat;
   real m_out;
   bit  m_settled;
   bit  m_pp;
   bit  m_mp;

   typedef struct {
      bit en;
      bit clr;
      bit p;
      bit m;
      int exp_count;
      bit exp_sat;
   } vec_t;

   vec_t vecs[$];

   function automatic real fabs(input real x);
      return (x < 0.0) ? -x : x;
   endfunction

   task automatic check_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_real(input string name, input real act, input real exp);
      n_cmp++;
      if (fabs(act - exp) > TOL) begin
         n_bad++;
         $display("FAIL %s: got %f, expected %f at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_count = 0; m_sat = 0; m_out = 0.0; m_settled = 1; m_pp = 0; m_mp = 0;
   endtask

   // One clock edge of the behaviour, using pre-edge state and inputs.
   task automatic model_edge(input bit en, input bit clr, input bit p, input bit m);
      bit  rp;
      bit  rm;
      int  want;
      real tgt;
      real d;
      rp   = p && !m_pp;
      rm   = m && !m_mp;
      m_pp = p;
      m_mp = m;
      tgt  = m_count * LSB;
      d    = tgt - m_out;
      if (clr) begin
         m_count = 0;
         m_sat   = 0;
      end else if (en && (rp != rm)) begin
         want = m_count + (rp ? 1 : -1);
         if (want > LIMIT || want < -LIMIT) m_sat = 1;
         else m_count = want;
      end
      if (d > SLEW + TOL) m_out = m_out + SLEW;
      else if (d < -(SLEW + TOL)) m_out = m_out - SLEW;
      else m_out = tgt;
      m_settled = fabs(m_out - m_count * LSB) < TOL;
   endtask

   task automatic check_model(input string tag);
      check_int({tag, "_count"}, int'(bus.count), m_count);
      check_int({tag, "_sat"}, int'(bus.sat), int'(m_sat));
      check_real({tag, "_out"}, bus.out, m_out);
      check_int({tag, "_settled"}, int'(bus.settled), int'(m_settled));
   endtask

   task automatic step(input bit en, input bit clr, input bit p, input bit m);
      @(negedge clk);
      bus.enable = en; bus.clear = clr; bus.plus_pulse = p; bus.minus_pulse = m;
      model_edge(en, clr, p, m);
      @(posedge clk);
      #1;
      check_model("model");
   endtask

   task automatic pulse(input bit up);
      step(1, 0, up, !up);
      step(1, 0, 0, 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst = 1'b0;
      bus.enable = 0; bus.clear = 0; bus.plus_pulse = 0; bus.minus_pulse = 0;
      #1;
      model_reset();
      check_int("rst_count", int'(bus.count), 0);
      check_int("rst_sat", int'(bus.sat), 0);
      check_real("rst_out", bus.out, 0.0);
      check_int("rst_settled", int'(bus.settled), 1);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      real prev;
      bit  mono;
      rst = 1'b0;
      bus.enable = 0; bus.clear = 0; bus.plus_pulse = 0; bus.minus_pulse = 0;
      model_reset();
      #12;
      check_int("init_count", int'(bus.count), 0);
      check_real("init_out", bus.out, 0.0);
      check_int("init_settled", int'(bus.settled), 1);
      rst = 1'b1;

      // Single held pulse, cancelling pair, gating, clear-with-plus, minus.
      vecs = '{
         '{1, 0, 1, 0, 1, 0}, '{1, 0, 1, 0, 1, 0}, '{1, 0, 1, 0, 1, 0},
         '{1, 0, 1, 0, 1, 0}, '{1, 0, 1, 0, 1, 0}, '{1, 0, 0, 0, 1, 0},
         '{1, 0, 1, 1, 1, 0}, '{1, 0, 0, 0, 1, 0}, '{0, 0, 1, 0, 1, 0},
         '{1, 0, 1, 0, 1, 0}, '{1, 0, 0, 0, 1, 0}, '{1, 0, 1, 0, 2, 0},
         '{1, 0, 0, 0, 2, 0}, '{1, 1, 1, 0, 0, 0}, '{1, 0, 0, 0, 0, 0},
         '{1, 0, 0, 1, -1, 0}, '{1, 0, 0, 0, -1, 0}
      };
      foreach (vecs[i]) begin
         step(vecs[i].en, vecs[i].clr, vecs[i].p, vecs[i].m);
         check_int("tbl_count", int'(bus.count), vecs[i].exp_count);
         check_int("tbl_sat", int'(bus.sat), int'(vecs[i].exp_sat));
         if (i == 0) begin
            check_real("single_out_lag", bus.out, 0.0);
            check_int("single_unsettled", int'(bus.settled), 0);
         end
         if (i == 1) begin
            check_real("single_out", bus.out, 0.01);
            check_int("single_settled", int'(bus.settled), 1);
         end
      end

      // Ramp: build count 20, then clear so out slews 0.20 -> 0.0 in 0.05 steps.
      do_reset();
      for (int i = 0; i < 20; i++) pulse(1);
      idle(3);
      check_int("ramp_count", int'(bus.count), 20);
      check_real("ramp_top", bus.out, 0.20);
      step(1, 1, 0, 0);
      check_real("ramp_e0", bus.out, 0.20);
      check_int("ramp_e0_settled", int'(bus.settled), 0);
      step(1, 0, 0, 0);
      check_real("ramp_e1", bus.out, 0.15);
      step(1, 0, 0, 0);
      check_real("ramp_e2", bus.out, 0.10);
      check_int("ramp_e2_settled", int'(bus.settled), 0);

      // Continue down mid-ramp with 20 minus pulses: monotonic, never below -0.20.
      prev = bus.out;
      mono = 1;
      for (int i = 0; i < 20; i++) begin
         pulse(0);
         if (bus.out > prev + TOL || bus.out < -0.20 - TOL) mono = 0;
         prev = bus.out;
      end
      idle(6);
      check_int("rev_monotonic", int'(mono), 1);
      check_int("rev_count", int'(bus.count), -20);
      check_real("rev_out", bus.out, -0.20);
      check_int("rev_settled", int'(bus.settled), 1);

      // Asynchronous reset mid-operation.
      do_reset();
      for (int i = 0; i < 37; i++) pulse(1);
      idle(2);
      check_int("pre_rst_count", int'(bus.count), 37);
      do_reset();

      // Positive and negative saturation.
      for (int i = 0; i < 390; i++) pulse(1);
      check_int("sat_pos_count", int'(bus.count), LIMIT);
      check_int("sat_pos_flag", int'(bus.sat), 1);
      pulse(0);
      check_int("sat_minus_count", int'(bus.count), LIMIT - 1);
      check_int("sat_sticky", int'(bus.sat), 1);
      step(1, 1, 0, 0);
      check_int("sat_clr_count", int'(bus.count), 0);
      check_int("sat_clr_flag", int'(bus.sat), 0);
      for (int i = 0; i < 390; i++) pulse(0);
      check_int("sat_neg_count", int'(bus.count), -LIMIT);
      check_int("sat_neg_flag", int'(bus.sat), 1);
      step(1, 1, 0, 0);

      // Randomized run against the model.
      for (int i = 0; i < 2000; i++) begin
         step($urandom_range(0, 9) != 0, $urandom_range(0, 99) == 0,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
